// File: rtl/ge_link_speed_ctrl.sv
// Per-channel GE/MII link-speed controller: sync + filter + hold-off + guarded clock-select switch.
// Optional per-channel select-change counters are built when GE_LINK_STATS_EN is defined.
module ge_link_speed_ctrl #(
    parameter int NUM_CH       = 1,
    parameter int TIMER_W      = 24,
    parameter int HOLD_CYCLES  = 16777215,
    parameter int FILT_CYCLES  = 4,
    parameter int GUARD_CYCLES = 8
) (
    input  logic                 SYS_CLK,
    input  logic                 SYS_RSTN,
    input  logic [NUM_CH-1:0]    GMII_GE_IND,
    input  logic [NUM_CH-1:0]    FORCE_GE,
    input  logic [NUM_CH-1:0]    FORCE_MII,
    output logic [NUM_CH-1:0]    GE_SEL,
    output logic [NUM_CH-1:0]    TX_CLK_EN,
    output logic [NUM_CH-1:0]    SPEED_CHG,
    output logic [16*NUM_CH-1:0] CHG_CNT
);

    localparam int FW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES + 1) : 1;
    localparam int GW = $clog2(GUARD_CYCLES);

    typedef enum logic [2:0] {
        ST_MII,
        ST_TO_GE,
        ST_GE,
        ST_HOLD,
        ST_TO_MII
    } state_t;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [1:0]         r_sync;
        state_t             r_state, w_state_nx;
        logic [FW-1:0]      r_filt, w_filt_nx;
        logic [GW-1:0]      r_guard, w_guard_nx;
        logic [TIMER_W-1:0] r_timer, w_timer_nx;
        logic               r_sel, w_sel_nx;
        logic               r_en, w_en_nx;
        logic               r_chg, w_chg_nx;
        logic               w_ind;

        assign w_ind = FORCE_MII[ch] ? 1'b0 : (FORCE_GE[ch] ? 1'b1 : r_sync[1]);

        always_ff @(posedge SYS_CLK or negedge SYS_RSTN) begin
            if (!SYS_RSTN) begin
                r_sync  <= 2'b00;
                r_state <= ST_MII;
                r_filt  <= '0;
                r_guard <= '0;
                r_timer <= '0;
                r_sel   <= 1'b0;
                r_en    <= 1'b1;
                r_chg   <= 1'b0;
            end else begin
                r_sync  <= {r_sync[0], GMII_GE_IND[ch]};
                r_state <= w_state_nx;
                r_filt  <= w_filt_nx;
                r_guard <= w_guard_nx;
                r_timer <= w_timer_nx;
                r_sel   <= w_sel_nx;
                r_en    <= w_en_nx;
                r_chg   <= w_chg_nx;
            end
        end

        always_comb begin
            w_state_nx = r_state;
            w_filt_nx  = r_filt;
            w_guard_nx = r_guard;
            w_timer_nx = r_timer;
            w_sel_nx   = r_sel;
            w_en_nx    = r_en;
            w_chg_nx   = 1'b0;
            case (r_state)
                ST_MII: begin
                    if (!w_ind) begin
                        w_filt_nx = '0;
                    end else if (r_filt == FW'(FILT_CYCLES - 1)) begin
                        w_state_nx = ST_TO_GE;
                        w_filt_nx  = '0;
                        w_guard_nx = '0;
                        w_en_nx    = 1'b0;
                    end else begin
                        w_filt_nx = r_filt + 1'b1;
                    end
                end
                // Guard: enable held low for the whole window, select flips at its midpoint.
                ST_TO_GE, ST_TO_MII: begin
                    if (r_guard == GW'(GUARD_CYCLES / 2 - 1)) begin
                        w_sel_nx = (r_state == ST_TO_GE);
                        w_chg_nx = 1'b1;
                    end
                    if (r_guard == GW'(GUARD_CYCLES - 1)) begin
                        w_guard_nx = '0;
                        w_en_nx    = 1'b1;
                        w_state_nx = (r_state == ST_TO_GE) ? ST_GE : ST_MII;
                    end else begin
                        w_guard_nx = r_guard + 1'b1;
                    end
                end
                ST_GE: begin
                    if (!w_ind) begin
                        w_state_nx = ST_HOLD;
                        w_timer_nx = '0;
                    end
                end
                ST_HOLD: begin
                    if (w_ind) begin
                        w_state_nx = ST_GE;
                        w_timer_nx = '0;
                    end else if (r_timer == TIMER_W'(HOLD_CYCLES - 1)) begin
                        w_state_nx = ST_TO_MII;
                        w_timer_nx = '0;
                        w_guard_nx = '0;
                        w_en_nx    = 1'b0;
                    end else if (r_timer != '1) begin
                        w_timer_nx = r_timer + 1'b1;
                    end
                end
                default: begin
                    w_state_nx = ST_MII;
                end
            endcase
        end

        assign GE_SEL[ch]    = r_sel;
        assign TX_CLK_EN[ch] = r_en;
        assign SPEED_CHG[ch] = r_chg;

`ifdef GE_LINK_STATS_EN
        logic [15:0] r_cnt;

        // Counts the same edge that raises SPEED_CHG, so the count and pulse appear together.
        always_ff @(posedge SYS_CLK or negedge SYS_RSTN) begin
            if (!SYS_RSTN) begin
                r_cnt <= 16'h0000;
            end else if (w_chg_nx) begin
                r_cnt <= r_cnt + 16'h0001;
            end
        end

        assign CHG_CNT[16*ch +: 16] = r_cnt;
`else
        assign CHG_CNT[16*ch +: 16] = 16'h0000;
`endif
    end

endmodule

// File: tb/tb_ge_link_speed_ctrl.sv
// Randomized bench for ge_link_speed_ctrl with a cycle-level speed/run-length reference model.
module tb_ge_link_speed_ctrl;

    localparam int NUM_CH = 4;
    localparam int TIMER_W = 8;
    localparam int HOLD = 64;
    localparam int FILT = 4;
    localparam int GUARD = 8;

    logic                 clk;
    logic                 rst_n;
    logic [NUM_CH-1:0]    gmii, fge, fmii;
    logic [NUM_CH-1:0]    ge_sel, tx_en, spd_chg;
    logic [16*NUM_CH-1:0] chg_cnt;

    int n_chk = 0;
    int n_err = 0;

    // Model: current speed, whether a guard is running and where, and how many
    // consecutive cycles the indication has disagreed with the current speed.
    int m_s1[NUM_CH], m_s2[NUM_CH], m_ge[NUM_CH], m_en[NUM_CH], m_chg[NUM_CH];
    int m_in_guard[NUM_CH], m_gpos[NUM_CH], m_run[NUM_CH], m_cnt[NUM_CH];

    ge_link_speed_ctrl #(
        .NUM_CH(NUM_CH), .TIMER_W(TIMER_W), .HOLD_CYCLES(HOLD),
        .FILT_CYCLES(FILT), .GUARD_CYCLES(GUARD)
    ) dut (
        .SYS_CLK(clk), .SYS_RSTN(rst_n), .GMII_GE_IND(gmii),
        .FORCE_GE(fge), .FORCE_MII(fmii), .GE_SEL(ge_sel),
        .TX_CLK_EN(tx_en), .SPEED_CHG(spd_chg), .CHG_CNT(chg_cnt)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_ge[c] = 0; m_en[c] = 1; m_chg[c] = 0;
            m_in_guard[c] = 0; m_gpos[c] = 0; m_run[c] = 0; m_cnt[c] = 0;
        end
    endfunction

    function automatic void model_step();
        int ind;
        for (int c = 0; c < NUM_CH; c++) begin
            ind = fmii[c] ? 0 : (fge[c] ? 1 : m_s2[c]);
            m_chg[c] = 0;
            if (m_in_guard[c] != 0) begin
                if (m_gpos[c] == GUARD / 2 - 1) begin
                    m_ge[c] = 1 - m_ge[c];
                    m_chg[c] = 1;
                    m_cnt[c] = (m_cnt[c] + 1) % 65536;
                end
                if (m_gpos[c] == GUARD - 1) begin
                    m_in_guard[c] = 0;
                    m_en[c] = 1;
                    m_run[c] = 0;
                end
                m_gpos[c]++;
            end else begin
                m_run[c] = (ind == m_ge[c]) ? 0 : m_run[c] + 1;
                // Rising needs FILT agreeing cycles; falling needs one cycle to enter
                // hold-off plus HOLD more cycles of low indication.
                if ((m_ge[c] == 0 && m_run[c] == FILT) || (m_ge[c] == 1 && m_run[c] == HOLD + 1)) begin
                    m_in_guard[c] = 1;
                    m_gpos[c] = 0;
                    m_en[c] = 0;
                end
            end
            m_s2[c] = m_s1[c];
            m_s1[c] = int'(gmii[c]);
        end
    endfunction

    task automatic check_outputs();
        int exp_cnt;
        for (int c = 0; c < NUM_CH; c++) begin
`ifdef GE_LINK_STATS_EN
            exp_cnt = m_cnt[c];
`else
            exp_cnt = 0;
`endif
            chk($sformatf("ge_sel[%0d]", c), 32'(ge_sel[c]), 32'(m_ge[c]));
            chk($sformatf("tx_clk_en[%0d]", c), 32'(tx_en[c]), 32'(m_en[c]));
            chk($sformatf("speed_chg[%0d]", c), 32'(spd_chg[c]), 32'(m_chg[c]));
            chk($sformatf("chg_cnt[%0d]", c), 32'(chg_cnt[16*c +: 16]), 32'(exp_cnt));
        end
    endtask

    task automatic check_defaults(input string tag);
        for (int c = 0; c < NUM_CH; c++) begin
            chk($sformatf("%s_sel[%0d]", tag, c), 32'(ge_sel[c]), 32'd0);
            chk($sformatf("%s_en[%0d]", tag, c), 32'(tx_en[c]), 32'd1);
            chk($sformatf("%s_chg[%0d]", tag, c), 32'(spd_chg[c]), 32'd0);
            chk($sformatf("%s_cnt[%0d]", tag, c), 32'(chg_cnt[16*c +: 16]), 32'd0);
        end
    endtask

    // One clock: model advances on the edge, outputs compared on the following falling edge.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int seg_left[NUM_CH];
    logic lvl[NUM_CH];

    initial begin
        int en_low, pulses, lat, found;
        logic [NUM_CH-1:0] sel_before;
        int exp_stat;

        rst_n = 1'b0; gmii = '0; fge = '0; fmii = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_defaults("reset");
        rst_n = 1'b1;
        steps(2);

        // Short pulse must be filtered out.
        gmii[0] = 1'b1; steps(3);
        gmii[0] = 1'b0; steps(20);
        chk("glitch_sel", 32'(ge_sel[0]), 32'd0);

        // Longer pulse: measure latency, enable-low width and pulse count.
        gmii[0] = 1'b1;
        en_low = 0; pulses = 0; lat = -1;
        for (int i = 1; i <= 40; i++) begin
            if (i == 11) gmii[0] = 1'b1;
            step();
            if (!tx_en[0]) begin en_low++; if (lat < 0) lat = i; end
            if (spd_chg[0]) pulses++;
        end
        chk("rise_latency", 32'(lat), 32'(2 + FILT));
        chk("guard_len", 32'(en_low), 32'(GUARD));
        chk("rise_pulses", 32'(pulses), 32'd1);
        chk("rise_sel", 32'(ge_sel[0]), 32'd1);

        // Hold-off: a 40-cycle drop is absorbed.
        gmii[0] = 1'b0; steps(40);
        gmii[0] = 1'b1; steps(20);
        chk("hold_keep_sel", 32'(ge_sel[0]), 32'd1);

        // Sustained drop: enable falls after sync + hold entry + full window.
        gmii[0] = 1'b0;
        lat = -1; en_low = 0;
        for (int i = 1; i <= 90; i++) begin
            step();
            if (!tx_en[0]) begin en_low++; if (lat < 0) lat = i; end
        end
        chk("hold_latency", 32'(lat), 32'(2 + 1 + HOLD));
        chk("fall_guard_len", 32'(en_low), 32'(GUARD));
        chk("fall_sel", 32'(ge_sel[0]), 32'd0);

        // FORCE_MII beats FORCE_GE; releasing it lets the filter and guard run.
        gmii[1] = 1'b1; fge[1] = 1'b1; fmii[1] = 1'b1;
        steps(30);
        chk("force_both_sel", 32'(ge_sel[1]), 32'd0);
        fmii[1] = 1'b0;
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (ge_sel[1] && lat < 0) lat = i;
        end
        chk("force_release_lat", 32'(lat), 32'(FILT + GUARD / 2));
        fge[1] = 1'b0; gmii[1] = 1'b0; steps(100);

        // Channel 2 switches alone; reset lands at guard cycle 3.
        sel_before = ge_sel;
        gmii[2] = 1'b1;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            step();
            if (m_in_guard[2] != 0 && m_gpos[2] == 3) found = 1;
        end
        chk("midguard_seen", 32'(found), 32'd1);
        chk("others_static", 32'(ge_sel & 4'b1011), 32'(sel_before & 4'b1011));
        chk("others_en", 32'(tx_en & 4'b1011), 32'hb);
        rst_n = 1'b0;
        #1;
        check_defaults("midguard_rst");
        model_reset();
        gmii = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        steps(2);

        // Three full up/down cycles on channel 0.
        for (int k = 0; k < 3; k++) begin
            gmii[0] = 1'b1; steps(20);
            gmii[0] = 1'b0; steps(90);
        end
`ifdef GE_LINK_STATS_EN
        exp_stat = 6;
`else
        exp_stat = 0;
`endif
        chk("stats_ch0", 32'(chg_cnt[15:0]), 32'(exp_stat));

        // Randomized segments per channel.
        for (int c = 0; c < NUM_CH; c++) begin seg_left[c] = 0; lvl[c] = 1'b0; end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (seg_left[c] == 0) begin
                    int r, f;
                    lvl[c] = ~lvl[c];
                    r = $urandom_range(0, 9);
                    if (r < 4) seg_left[c] = $urandom_range(1, 5);
                    else if (r < 7) seg_left[c] = $urandom_range(8, 30);
                    else seg_left[c] = $urandom_range(66, 100);
                    f = $urandom_range(0, 9);
                    fge[c]  = (f == 0 || f == 2);
                    fmii[c] = (f == 1 || f == 2);
                end
                seg_left[c]--;
                gmii[c] = lvl[c];
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
